// File: rtl/execute_stage.sv
// EX stage of a five-stage RV32I-style pipeline: operand forwarding, ALU,
// branch/jump resolution and the EX/MEM pipeline register.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic [1:0]  ResultSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] ImmExtE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RDE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [4:0]  RDM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  logic [31:0] src_a_s;
  logic [31:0] write_data_s;
  logic [31:0] src_b_s;
  logic [31:0] alu_result_s;
  logic        zero_s;

  // 2'b10 feeds back the value held in the EX/MEM register, so a dependent
  // instruction right behind its producer needs no stall.
  function automatic logic [31:0] fwd_mux(
    input logic [1:0]  sel,
    input logic [31:0] reg_val,
    input logic [31:0] result_w,
    input logic [31:0] alu_m
  );
    logic [31:0] res;
    case (sel)
      2'b01:   res = result_w;
      2'b10:   res = alu_m;
      default: res = reg_val;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] alu_op(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] res;
    case (op)
      3'b000:  res = a + b;
      3'b001:  res = a - b;
      3'b010:  res = a & b;
      3'b011:  res = a | b;
      3'b101:  res = {31'd0, ($signed(a) < $signed(b))};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Operand selection, ALU and branch/jump resolution.
  always_comb begin
    src_a_s      = fwd_mux(ForwardAE, RD1E, ResultW, ALUResultM);
    write_data_s = fwd_mux(ForwardBE, RD2E, ResultW, ALUResultM);
    if (ALUSrcE) begin
      src_b_s = ImmExtE;
    end else begin
      src_b_s = write_data_s;
    end
    alu_result_s = alu_op(ALUControlE, src_a_s, src_b_s);
    zero_s       = (alu_result_s == 32'd0);
    PCSrcE       = (BranchE & zero_s) | JumpE;
    PCTargetE    = PCE + ImmExtE;
  end

  // EX/MEM pipeline register; bubbles arrive as all-zero controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      RDM        <= 5'd0;
      ALUResultM <= 32'd0;
      WriteDataM <= 32'd0;
      PCPlus4M   <= 32'd0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RDM        <= RDE;
      ALUResultM <= alu_result_s;
      WriteDataM <= write_data_s;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push expected EX/MEM
// contents into a queue that a monitor pops after every rising edge.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RDE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RDM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  typedef struct {
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RDE(RDE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .RDM(RDM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, " RegWriteM"},  {31'd0, RegWriteM}, 32'd0);
    chk({tag, " MemWriteM"},  {31'd0, MemWriteM}, 32'd0);
    chk({tag, " ResultSrcM"}, {30'd0, ResultSrcM}, 32'd0);
    chk({tag, " RDM"},        {27'd0, RDM}, 32'd0);
    chk({tag, " ALUResultM"}, ALUResultM, 32'd0);
    chk({tag, " WriteDataM"}, WriteDataM, 32'd0);
    chk({tag, " PCPlus4M"},   PCPlus4M, 32'd0);
  endtask

  task automatic clear_in();
    RegWriteE = 1'b0; ALUSrcE = 1'b0; MemWriteE = 1'b0; BranchE = 1'b0; JumpE = 1'b0;
    ResultSrcE = 2'b00; ALUControlE = 3'b000;
    RD1E = 32'd0; RD2E = 32'd0; ImmExtE = 32'd0; PCE = 32'd0; PCPlus4E = 32'd0;
    RDE = 5'd0; ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 32'd0;
  endtask

  // Checks the same-cycle outputs, then queues the expected EX/MEM capture.
  task automatic issue(input string name, input logic pcsrc, input logic [31:0] pctgt,
                       input logic rw, input logic mw, input logic [1:0] rs,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc4);
    exp_t e;
    #1;
    chk({name, " PCSrcE"}, {31'd0, PCSrcE}, {31'd0, pcsrc});
    chk({name, " PCTargetE"}, PCTargetE, pctgt);
    e.rw = rw; e.mw = mw; e.rs = rs; e.rd = rd; e.alu = alu; e.wd = wd; e.pc4 = pc4;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the EX/MEM register against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("mon RegWriteM",  {31'd0, RegWriteM},  {31'd0, e.rw});
        chk("mon MemWriteM",  {31'd0, MemWriteM},  {31'd0, e.mw});
        chk("mon ResultSrcM", {30'd0, ResultSrcM}, {30'd0, e.rs});
        chk("mon RDM",        {27'd0, RDM},        {27'd0, e.rd});
        chk("mon ALUResultM", ALUResultM, e.alu);
        chk("mon WriteDataM", WriteDataM, e.wd);
        chk("mon PCPlus4M",   PCPlus4M, e.pc4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    clear_in();
    #2;
    chk_regs_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // add 5+7 -> 12
    clear_in(); RD1E = 32'd5; RD2E = 32'd7; RDE = 5'd3; RegWriteE = 1'b1;
    issue("add", 1'b0, 32'd0, 1'b1, 1'b0, 2'b00, 5'd3, 32'd12, 32'd7, 32'd0);
    @(negedge clk);
    // ForwardAE=10 picks ALUResultM=12, +imm 1 -> 13
    clear_in(); ForwardAE = 2'b10; ImmExtE = 32'd1; ALUSrcE = 1'b1; RDE = 5'd4;
    RegWriteE = 1'b1; ResultSrcE = 2'b01;
    issue("fwdA10", 1'b0, 32'd1, 1'b1, 1'b0, 2'b01, 5'd4, 32'd13, 32'd0, 32'd0);
    @(negedge clk);
    // ForwardBE=01 picks ResultW for store data
    clear_in(); ForwardBE = 2'b01; ResultW = 32'hAA; MemWriteE = 1'b1; RD2E = 32'h55;
    RD1E = 32'h10; ImmExtE = 32'h20; ALUSrcE = 1'b1; ResultSrcE = 2'b10; RDE = 5'd7;
    issue("fwdB01", 1'b0, 32'h20, 1'b0, 1'b1, 2'b10, 5'd7, 32'h30, 32'hAA, 32'd0);
    @(negedge clk);
    // beq taken
    clear_in(); BranchE = 1'b1; ALUControlE = 3'b001; RD1E = 32'd9; RD2E = 32'd9;
    PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
    issue("beq_taken", 1'b1, 32'hF8, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd9, 32'd0);
    @(negedge clk);
    // beq not taken
    clear_in(); BranchE = 1'b1; ALUControlE = 3'b001; RD1E = 32'd9; RD2E = 32'd8;
    PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
    issue("beq_not", 1'b0, 32'hF8, 1'b0, 1'b0, 2'b00, 5'd0, 32'd1, 32'd8, 32'd0);
    @(negedge clk);
    // jump
    clear_in(); JumpE = 1'b1; PCPlus4E = 32'h104; RD1E = 32'd1; RD2E = 32'd2;
    issue("jump", 1'b1, 32'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd3, 32'd2, 32'h104);
    @(negedge clk);
    // slt -1 < 1 -> 1, branch not taken since result nonzero
    clear_in(); ALUControlE = 3'b101; RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; BranchE = 1'b1;
    issue("slt_neg", 1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd1, 32'd1, 32'd0);
    @(negedge clk);
    // slt 1 < -1 -> 0, zero makes branch taken
    clear_in(); ALUControlE = 3'b101; RD1E = 32'd1; RD2E = 32'hFFFF_FFFF; BranchE = 1'b1;
    issue("slt_pos", 1'b1, 32'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'hFFFF_FFFF, 32'd0);
    @(negedge clk);
    clear_in(); ALUControlE = 3'b010; RD1E = 32'd6; RD2E = 32'd3;
    issue("and", 1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd2, 32'd3, 32'd0);
    @(negedge clk);
    clear_in(); ALUControlE = 3'b011; RD1E = 32'd6; RD2E = 32'd3;
    issue("or", 1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd7, 32'd3, 32'd0);
    @(negedge clk);
    clear_in(); ALUControlE = 3'b111; RD1E = 32'd6; RD2E = 32'd3;
    issue("op111", 1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd3, 32'd0);
    @(negedge clk);
    clear_in(); ALUControlE = 3'b100; RD1E = 32'd6; RD2E = 32'd3;
    issue("op100", 1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd3, 32'd0);
    @(negedge clk);
    // 0xFFFFFFFF + 1 wraps to 0
    clear_in(); RD1E = 32'hFFFF_FFFF; ImmExtE = 32'd1; ALUSrcE = 1'b1;
    issue("wrap_add", 1'b0, 32'd1, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    // 0 - 1 wraps to 0xFFFFFFFF
    clear_in(); ALUControlE = 3'b001; RD2E = 32'd1;
    issue("wrap_sub", 1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    @(negedge clk);
    // ForwardA/B = 11 behave like 00
    clear_in(); ForwardAE = 2'b11; ForwardBE = 2'b11; RD1E = 32'h40; RD2E = 32'd2;
    ResultW = 32'h999;
    issue("fwd11", 1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h42, 32'd2, 32'd0);
    @(negedge clk);
    // ForwardBE=10 picks previous ALUResultM=0x42
    clear_in(); ForwardBE = 2'b10; RD1E = 32'd1; RD2E = 32'd5;
    issue("fwdB10", 1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h43, 32'h42, 32'd0);
    @(negedge clk);
    // load nonzero state for the reset test
    clear_in(); RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 2'b11; RDE = 5'd31;
    RD1E = 32'h11; RD2E = 32'h22; PCPlus4E = 32'h200;
    issue("preload", 1'b0, 32'd0, 1'b1, 1'b1, 2'b11, 5'd31, 32'h33, 32'h22, 32'h200);
    @(negedge clk);
    // asynchronous reset between edges; combinational path still live
    clear_in(); ForwardAE = 2'b10; ALUSrcE = 1'b1; BranchE = 1'b1; ALUControlE = 3'b001;
    PCE = 32'h300; RD1E = 32'h77;
    rst = 1'b0;
    #1;
    chk_regs_zero("async_rst");
    chk("rst PCSrcE", {31'd0, PCSrcE}, 32'd1);
    chk("rst PCTargetE", PCTargetE, 32'h300);
    @(posedge clk);
    #1;
    chk_regs_zero("rst_held");
    @(negedge clk);
    rst = 1'b1;
    clear_in(); RD1E = 32'd2; RD2E = 32'd3; RDE = 5'd9; RegWriteE = 1'b1; PCPlus4E = 32'h44;
    issue("post_rst", 1'b0, 32'd0, 1'b1, 1'b0, 2'b00, 5'd9, 32'd5, 32'd3, 32'h44);
    @(negedge clk);
    clear_in();

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The module SHALL have no parameters; all datapaths are fixed at 32 bits and register addresses at 5 bits.
REQ-002 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low; all state clears while rst=0.
REQ-004 RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE  input  1 each  ID/EX control bits.
REQ-005 ResultSrcE  input  2  writeback source select, passed through to the memory stage.
REQ-006 ALUControlE  input  3  ALU operation select.
REQ-007 RD1E, RD2E, ImmExtE, PCE, PCPlus4E  input  32 each  ID/EX operands, immediate, PC and PC+4.
REQ-008 RDE  input  5  destination register address.
REQ-009 ForwardAE, ForwardBE  input  2 each  operand forwarding selects from the hazard unit.
REQ-010 ResultW  input  32  writeback-stage result, used for forwarding.
REQ-011 PCSrcE  output  1  branch/jump taken, to fetch.
REQ-012 PCTargetE  output  32  branch/jump target, to fetch.
REQ-013 RegWriteM, MemWriteM  output  1 each  registered control bits.
REQ-014 ResultSrcM  output  2  registered writeback select.
REQ-015 RDM  output  5  registered destination address.
REQ-016 ALUResultM, WriteDataM, PCPlus4M  output  32 each  registered EX/MEM data.

Function
REQ-017 SrcAE SHALL be selected by ForwardAE as follows: 00 selects RD1E, 01 selects ResultW, 10 selects the current registered ALUResultM, 11 selects RD1E.
REQ-018 WriteDataE SHALL be selected from RD2E by ForwardBE using the same encoding as REQ-017.
REQ-019 SrcBE SHALL be ImmExtE when ALUSrcE=1 and WriteDataE otherwise.
REQ-020 The ALU SHALL compute ALUControlE operations as follows: 000 add, 001 sub, 010 AND, 011 OR, 101 signed set-less-than (result 1 or 0); any other code SHALL yield 0.
REQ-021 Add and sub SHALL wrap modulo 2^32 with no overflow flag.
REQ-022 ZeroE SHALL be 1 exactly when the 32-bit ALU result is 0.
REQ-023 PCSrcE SHALL equal (BranchE AND ZeroE) OR JumpE, combinationally in the same cycle.
REQ-024 PCTargetE SHALL equal PCE+ImmExtE modulo 2^32, combinationally.
REQ-025 On each rising clk edge with rst=1, the EX/MEM register SHALL capture the following (one-cycle latency):
- RegWriteE, MemWriteE, ResultSrcE, RDE
- ALU result
- WriteDataE (post-forwarding)
- PCPlus4E
REQ-026 BranchE, JumpE, ALUSrcE and ALUControlE SHALL NOT be registered beyond this stage.
REQ-027 ForwardAE=10 SHALL use the ALUResultM value held before the current edge, so back-to-back dependent instructions resolve without a stall.
REQ-028 The EX/MEM register SHALL have no enable or flush input; bubbles arrive as all-zero ID/EX controls.

Reset
REQ-029 When rst=0, the following SHALL be 0 immediately, without waiting for clk:
- RegWriteM, MemWriteM, RDM, ResultSrcM
- ALUResultM, WriteDataM, PCPlus4M
REQ-030 Reset asserted mid-operation SHALL discard the in-flight EX/MEM contents; the first edge after release SHALL capture the current inputs.
REQ-031 During reset, PCSrcE and PCTargetE SHALL continue to follow their combinational inputs, with ALUResultM=0 used for forwarding.

Verification
REQ-032 The bench SHALL cover this ALU case: RD1E=5, RD2E=7, ALUControlE=000, ALUSrcE=0, Forward=00, RDE=3, RegWriteE=1 -> after one edge, ALUResultM=12, RDM=3, RegWriteM=1.
REQ-033 The bench SHALL cover this forwarding case: cycle 1 computes 12 into ALUResultM; cycle 2 has ForwardAE=10, RD1E=0, ImmExtE=1, ALUSrcE=1, add -> ALUResultM=13; then ForwardBE=01 with ResultW=0xAA and MemWriteE=1 -> WriteDataM=0xAA.
REQ-034 The bench SHALL cover this branch case: BranchE=1, sub with RD1E=RD2E=9, PCE=0x100, ImmExtE=0xFFFFFFF8 -> PCSrcE=1 and PCTargetE=0xF8 in the same cycle; with RD2E=8 -> PCSrcE=0.
REQ-035 The bench SHALL cover this jump/SLT case: JumpE=1, PCPlus4E=0x104 -> PCSrcE=1 and PCPlus4M=0x104 after the edge; SLT with SrcA=0xFFFFFFFF, SrcB=1 -> 1; SLT with SrcA=1, SrcB=0xFFFFFFFF -> 0; ALUControlE=111 -> 0.
REQ-036 The bench SHALL cover this reset case: with registered outputs nonzero, drive rst=0 between edges -> all registered outputs are 0 before the next edge; release rst -> the next edge captures the current inputs.
REQ-037 The bench SHALL cover this wrap case: 0xFFFFFFFF+1 -> ALUResultM=0; 0-1 via sub -> 0xFFFFFFFF; ForwardAE=11 behaves identically to 00.
